audio_dac_tx: RTL

Serializing transmitter for the audio codec DAC path, the outbound counterpart of the ADC sample capture feeding the `aud_dat` port of the audio system. It accepts 32-bit stereo sample words over a valid/ready handshake and buffers them in a small FIFO. It generates the codec's bit clock and DAC left/right clock from the system clock, with the codec as clock slave, and shifts samples out in I2S format, MSB first.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/audio_tx_fifo.sv | 66 ++++++
 rtl/audio_dac_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants and types for the audio codec paths (DAC transmit and
// ADC capture). Frame geometry is I2S stereo: 64 bit clocks per frame,
// 32 per slot, 16 data bits per sample.
package audio_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BITS  = 64;

    localparam int SLOT_W      = $clog2(SLOT_BITS);
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } stereo_sample_t;

    // True for the frame positions that carry sample data. I2S delays the
    // MSB by one bit clock, so data occupies positions 1..16 of each slot.
    function automatic logic is_data_bit(input logic [BIT_CNT_W-1:0] bit_pos);
        logic [SLOT_W-1:0] slot_pos;
        slot_pos = bit_pos[SLOT_W-1:0];
        return (slot_pos != '0) && (slot_pos <= SLOT_W'(SAMPLE_BITS));
    endfunction

endpackage

// File: rtl/audio_tx_fifo.sv
// audio_tx_fifo
// Synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, wr_data   : write request and data (ignored when full)
//   pop             : advance read pointer (ignored when empty)
//   rd_data         : current head word
//   level           : number of words held
//   full, empty     : occupancy flags derived from level
module audio_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx
// I2S serializer for the codec DAC path. Buffers 32-bit stereo words
// (left = [31:16], right = [15:0]) and shifts them out MSB first, with the
// codec as clock slave.
// Ports:
//   clk_clk, reset_reset          : system clock, synchronous active-high reset
//   enable                        : run the serializer; low idles the serial pins
//   sample_data/valid/ready       : word input handshake
//   aud_bclk_export               : bit clock, period 2*CLK_DIV system clocks
//   aud_daclrck_export            : LR clock, 0 = left slot, 1 = right slot
//   aud_dacdat_export             : serial data, changes on BCLK fall
//   fifo_level                    : words buffered
//   underrun, underrun_clr        : sticky empty-at-frame-start flag and its clear
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          enable,
    input  logic [31:0]                   sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          aud_bclk_export,
    output logic                          aud_daclrck_export,
    output logic                          aud_dacdat_export,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic                  en_q;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_next;
    logic [SLOT_BITS-1:0]  shift_reg;
    stereo_sample_t        head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  enable_rise;
    logic                  div_wrap;
    logic                  fall_tick;
    logic                  frame_start;

    assign sample_ready = ~fifo_full;
    assign push         = sample_valid & sample_ready;

    // The enable-rise cycle restarts the divider rather than counting, so
    // BCLK rises exactly CLK_DIV cycles after the first pop.
    assign enable_rise  = enable & ~en_q;
    assign div_wrap     = enable & en_q & (div_cnt == DIV_LAST);
    assign fall_tick    = div_wrap & aud_bclk_export;
    assign bit_next     = bit_cnt + BIT_CNT_W'(1);
    assign frame_start  = enable_rise |
                          (fall_tick & (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)));
    assign pop          = frame_start & ~fifo_empty;

    audio_tx_fifo #(
        .WIDTH (SLOT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .reset   (reset_reset),
        .push    (push),
        .wr_data (sample_data),
        .pop     (pop),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            en_q               <= 1'b0;
            div_cnt            <= '0;
            bit_cnt            <= '0;
            aud_bclk_export    <= 1'b0;
            aud_daclrck_export <= 1'b0;
            aud_dacdat_export  <= 1'b0;
            shift_reg          <= '0;
            underrun           <= 1'b0;
        end else begin
            en_q <= enable;

            if (!enable || enable_rise) begin
                div_cnt            <= '0;
                bit_cnt            <= '0;
                aud_bclk_export    <= 1'b0;
                aud_daclrck_export <= 1'b0;
                aud_dacdat_export  <= 1'b0;
            end else begin
                div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                if (div_wrap) begin
                    aud_bclk_export <= ~aud_bclk_export;
                end
                if (fall_tick) begin
                    bit_cnt            <= bit_next;
                    aud_daclrck_export <= (bit_next >= BIT_CNT_W'(SLOT_BITS));
                    aud_dacdat_export  <= is_data_bit(bit_next) ? shift_reg[SLOT_BITS-1] : 1'b0;
                end
            end

            // Left bits leave from the top; after 16 shifts the right
            // sample sits at the top, ready for the right slot.
            if (frame_start) begin
                shift_reg <= pop ? head : '0;
            end else if (fall_tick && is_data_bit(bit_next)) begin
                shift_reg <= {shift_reg[SLOT_BITS-2:0], 1'b0};
            end

            if (underrun_clr) begin
                underrun <= 1'b0;
            end else if (frame_start && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
